// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatch slice: ctrl codes, data width,
// dispatcher FSM states and the queued op record.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [4:0] CTRL_NOP = 5'b00000;
  localparam logic [4:0] CTRL_SLL = 5'b00001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [4:0]        b;
    logic [4:0]        ctrl;
  } op_t;

endpackage

// File: rtl/alu_op_fifo.sv
// Op buffer for the dispatcher: synchronous FIFO of op_t records.
// The pointers carry one extra wrap bit so that full and empty can be told apart.
module alu_op_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  op_t  wdata,
  output op_t  rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  op_t         mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_dispatch.sv
// Issue stage in front of the iterative shifter: queues ops, launches SLLs,
// answers NOP/illegal ops directly. Optional WAIT watchdog: ALU_DISPATCH_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | pop and decode the FIFO head when one is queued
// ISSUE    | one-cycle sh_start pulse with sh_a/sh_b presented
// WAIT     | wait for a fresh sh_done (must drop once before it counts)
// RESP     | hold the response until res_ready
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [4:0]        op_b,
  input  logic [4:0]        op_ctrl,
  output logic [DATA_W-1:0] sh_a,
  output logic [4:0]        sh_b,
  output logic              sh_start,
  input  logic              sh_done,
  input  logic [DATA_W-1:0] sh_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err
);

  state_t state;
  op_t    wr_op;
  op_t    head;
  logic   full;
  logic   empty;
  logic   push;
  logic   pop;
  logic   seen_low;

  assign wr_op     = '{a: op_a, b: op_b, ctrl: op_ctrl};
  assign op_ready  = !full;
  assign push      = op_valid && !full;
  assign pop       = (state == ST_IDLE) && !empty;
  assign sh_start  = (state == ST_ISSUE);
  assign res_valid = (state == ST_RESP);

  alu_op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wr_op),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

`ifdef ALU_DISPATCH_TIMEOUT_EN
  localparam int            TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] wait_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sh_a     <= '0;
      sh_b     <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
      seen_low <= 1'b0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            if (head.ctrl == CTRL_SLL) begin
              sh_a  <= head.a;
              sh_b  <= head.b;
              state <= ST_ISSUE;
            end else if (head.ctrl == CTRL_NOP) begin
              res_data <= head.a;
              res_err  <= 1'b0;
              state    <= ST_RESP;
            end else begin
              res_data <= '0;
              res_err  <= 1'b1;
              state    <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          seen_low <= 1'b0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done level left over from the previous op only counts after it has dropped.
          if (!sh_done) seen_low <= 1'b1;
          if (seen_low && sh_done) begin
            res_data <= sh_result;
            res_err  <= 1'b0;
            state    <= ST_RESP;
          end
`ifdef ALU_DISPATCH_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            res_data <= '0;
            res_err  <= 1'b1;
            state    <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
`endif
        end
        ST_RESP: begin
          if (res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: queue-based response model, a
// behavioural shifter, and directed scenarios with literal expectations.
module tb_alu_dispatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [31:0] op_a = '0;
  logic [4:0]  op_b = '0;
  logic [4:0]  op_ctrl = '0;
  logic [31:0] sh_a;
  logic [4:0]  sh_b;
  logic        sh_start;
  logic        sh_done = 1'b0;
  logic [31:0] sh_result = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_err;

  alu_dispatch #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_ctrl   (op_ctrl),
    .sh_a      (sh_a),
    .sh_b      (sh_b),
    .sh_start  (sh_start),
    .sh_done   (sh_done),
    .sh_result (sh_result),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // ---------------- reference model: in-order responses ----------------
  typedef struct {
    logic [31:0] d;
    logic        e;
  } resp_t;

  resp_t       exp_q[$];
  logic [36:0] iss_q[$];

  function automatic resp_t ref_resp(input logic [31:0] a, input logic [4:0] b, input logic [4:0] c);
    resp_t r;
    if (c == 5'd0) begin r.d = a;      r.e = 1'b0; end
    else if (c == 5'd1) begin r.d = a << b; r.e = 1'b0; end
    else begin r.d = 32'd0;  r.e = 1'b1; end
    return r;
  endfunction

  int          start_cnt = 0;
  bit          in_wait = 0;
  logic [31:0] cur_a;
  logic [4:0]  cur_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      iss_q.delete();
      in_wait = 0;
    end else begin
      if (op_valid && op_ready) begin
        exp_q.push_back(ref_resp(op_a, op_b, op_ctrl));
        if (op_ctrl == 5'd1) iss_q.push_back({op_a, op_b});
      end
      if (sh_start) begin
        start_cnt++;
        if (iss_q.size() == 0) begin
          fail_now("unexpected_start", "sh_start=1 with no shift op outstanding, required 0");
        end else begin
          chk("sh_a", sh_a, iss_q[0][36:5]);
          chk("sh_b", {27'd0, sh_b}, {27'd0, iss_q[0][4:0]});
          cur_a = iss_q[0][36:5];
          cur_b = iss_q[0][4:0];
          void'(iss_q.pop_front());
          in_wait = 1;
        end
      end else if (in_wait) begin
        chk("sh_a_hold", sh_a, cur_a);
        chk("sh_b_hold", {27'd0, sh_b}, {27'd0, cur_b});
      end
      if (res_valid) begin
        in_wait = 0;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_resp", "res_valid=1 with no op outstanding, required 0");
        end else begin
          chk("res_data", res_data, exp_q[0].d);
          chk("res_err", {31'd0, res_err}, {31'd0, exp_q[0].e});
          if (res_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- behavioural shifter ----------------
  int sh_delay = 6;
  int stale_hold = 0;
  int done_cyc = 0;

  initial begin
    logic [31:0] la;
    logic [4:0]  lb;
    forever begin
      @(negedge clk);
      if (rst_n && sh_start) begin
        la = sh_a;
        lb = sh_b;
        @(posedge clk); #1;
        repeat (stale_hold) begin @(posedge clk); #1; end
        sh_done = 1'b0;
        repeat (sh_delay) begin @(posedge clk); #1; end
        sh_done   = 1'b1;
        sh_result = la << lb;
        done_cyc  = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int acc_cyc = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_op(input logic [31:0] a, input logic [4:0] b, input logic [4:0] c);
    int n;
    op_valid = 1'b1;
    op_a = a;
    op_b = b;
    op_ctrl = c;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (op_ready) break;
    end
    if (n == 200) fail_now("push_timeout", "op_ready stayed 0 for 200 cycles, required 1");
    @(posedge clk); #1;
    acc_cyc = cyc;
    op_valid = 1'b0;
  endtask

  task automatic wait_start(output int at);
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sh_start) break;
    end
    if (n == 200) fail_now("start_timeout", "sh_start stayed 0 for 200 cycles, required 1");
    at = cyc;
  endtask

  task automatic wait_resp(input int budget, output int at);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    if (n == budget) fail_now("resp_timeout", "res_valid stayed 0 past cycle budget, required 1");
    at = cyc;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !res_valid) break;
    end
    if (n == 300) fail_now("drain_timeout", "responses still outstanding after 300 cycles, required none");
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int st, rv, s0;

    #2;
    chk("rst_op_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_sh_start", {31'd0, sh_start}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_err", {31'd0, res_err}, 32'd0);
    chk("rst_sh_a", sh_a, 32'd0);
    chk("rst_sh_b", {27'd0, sh_b}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // basic shift
    res_ready = 1'b1;
    push_op(32'h0000_0001, 5'd4, 5'd1);
    wait_start(st);
    chk("sll_issue_lat", st - acc_cyc, 32'd1);
    chk("sll_sh_a", sh_a, 32'h0000_0001);
    chk("sll_sh_b", {27'd0, sh_b}, 32'd4);
    wait_resp(50, rv);
    chk("sll_res_data", res_data, 32'h0000_0010);
    chk("sll_res_err", {31'd0, res_err}, 32'd0);
    chk("sll_resp_lat", rv - done_cyc, 32'd1);
    wait_idle();

    // NOP bypass
    s0 = start_cnt;
    push_op(32'hDEAD_BEEF, 5'd7, 5'd0);
    wait_resp(20, rv);
    chk("nop_lat", rv - acc_cyc, 32'd1);
    chk("nop_res_data", res_data, 32'hDEAD_BEEF);
    chk("nop_res_err", {31'd0, res_err}, 32'd0);
    tick();
    @(negedge clk);
    chk("nop_valid_drop", {31'd0, res_valid}, 32'd0);
    chk("nop_no_start", start_cnt, s0);
    tick();

    // illegal ctrl under backpressure, next op must stay queued
    res_ready = 1'b0;
    s0 = start_cnt;
    push_op(32'h1234_5678, 5'd3, 5'h1F);
    push_op(32'h0000_0003, 5'd2, 5'd1);
    wait_resp(20, rv);
    for (int i = 0; i < 10; i++) begin
      chk("ill_valid", {31'd0, res_valid}, 32'd1);
      chk("ill_err", {31'd0, res_err}, 32'd1);
      chk("ill_data", res_data, 32'd0);
      @(negedge clk);
    end
    chk("ill_no_pop", start_cnt, s0);
    tick();
    res_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("ill_valid_drop", {31'd0, res_valid}, 32'd0);
    wait_resp(50, rv);
    chk("ill_next_data", res_data, 32'h0000_000C);
    wait_idle();

    // FIFO full with the first op stuck in RESP
    res_ready = 1'b0;
    push_op(32'h0000_00A1, 5'd0, 5'd0);
    push_op(32'h0000_0005, 5'd3, 5'd1);
    push_op(32'h0000_0007, 5'd0, 5'd2);
    push_op(32'h0000_00A4, 5'd0, 5'd0);
    push_op(32'h0000_0009, 5'd1, 5'd1);
    @(negedge clk);
    chk("full_op_ready", {31'd0, op_ready}, 32'd0);
    tick();
    op_valid = 1'b1;
    op_a = 32'h0000_0BAD;
    op_b = 5'd0;
    op_ctrl = 5'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_hold", {31'd0, op_ready}, 32'd0);
      tick();
    end
    op_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle();
    @(negedge clk);
    chk("drain_op_ready", {31'd0, op_ready}, 32'd1);
    tick();

    // stale done: previous done stays high into the next WAIT
    stale_hold = 3;
    push_op(32'h0000_00F0, 5'd4, 5'd1);
    wait_start(st);
    wait_resp(60, rv);
    chk("stale_lat", rv - st, 32'd11);
    chk("stale_data", res_data, 32'h0000_0F00);
    stale_hold = 0;
    wait_idle();

    // reset during WAIT with ops still queued
    sh_delay = 20;
    s0 = start_cnt;
    push_op(32'h0000_0001, 5'd1, 5'd1);
    push_op(32'h0000_0011, 5'd0, 5'd0);
    push_op(32'h0000_0022, 5'd0, 5'd0);
    tick();
    tick();
    chk("rst_mid_started", start_cnt, s0 + 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_mid_sh_a", sh_a, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_empty_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_empty_start", {31'd0, sh_start}, 32'd0);
    end
    repeat (25) tick();
    sh_delay = 6;

`ifdef ALU_DISPATCH_TIMEOUT_EN
    sh_delay = 500;
    push_op(32'h0000_0001, 5'd2, 5'd1);
    exp_q[exp_q.size() - 1] = '{d: 32'd0, e: 1'b1};
    wait_start(st);
    wait_resp(150, rv);
    chk("to_lat", rv - st, 32'd65);
    chk("to_err", {31'd0, res_err}, 32'd1);
    chk("to_data", res_data, 32'd0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
